fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and interlock unit for the lab pipeline, generalising the fixed two-operand, fixed-stage forwarding logic.
- Tracks every in-flight register write in a FWD_DEPTH-deep shadow pipeline with per-entry result-latency countdowns, plus a per-register busy counter for long-latency ops (mul/div).
- Produces per-operand forward selects for NUM_SRC source operands, and one stall for the ID stage.

Parameters:
- REG_AW, 5, register address width (2**REG_AW architectural registers; register 0 hardwired zero).
- NUM_SRC, 2, source operands checked per issue.
- FWD_DEPTH, 3, forwardable producer stages (slot 1 = EX output ... slot FWD_DEPTH = WB).
- MAX_LAT, 15, maximum result latency in cycles; LAT_W = $clog2(MAX_LAT+1).
- SEL_W, $clog2(FWD_DEPTH+1), width of one forward select.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction in ID requests issue to EX this cycle
- issue_we  in  1  issuing instruction writes a register
- issue_rd  in  REG_AW  destination register
- issue_lat  in  LAT_W  cycles from issue until result is available (1 = ALU, 2 = load)
- flush  in  1  kill the issuing instruction (branch redirect)
- src_valid  in  NUM_SRC  operand i is actually read
- src_reg  in  NUM_SRC*REG_AW  operand register numbers, operand i at bits [i*REG_AW +: REG_AW]
- stall  out  1  hold PC/IF/ID and insert a bubble into EX
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = forward from slot k

Behaviour:
- State
  - slot[1..FWD_DEPTH], each {valid, we, rd, rem[LAT_W]}.
  - busy_cnt[r] for r = 1 .. 2**REG_AW-1, LAT_W bits each.
- Reset: asynchronous on rst_n low. All slots invalid, all busy_cnt = 0. With empty state, stall = 0 and fwd_sel = 0 for any inputs. Reset asserted mid-operation discards all pending hazards.
- Latency input: issue_lat = 0 is treated as 1; values above MAX_LAT are clamped to MAX_LAT.
- Register 0 handling: an entry with we=0 or rd=0 never matches. Register 0 is never forwarded, never stalls and is never marked busy.
- Per-operand lookup (combinational, operand i with src_valid and reg != 0):
  - Select the youngest matching slot (smallest k with valid && we && rd == reg).
  - If that slot has rem == 0: fwd_sel = k.
  - If that slot has rem != 0: raise a RAW stall.
  - If no slot matches and busy_cnt[reg] != 0: raise a RAW stall.
  - Otherwise fwd_sel = 0.
  - Youngest match always wins; an older ready copy is never used.
- WAW rule: issue_valid && issue_we && issue_rd != 0 && busy_cnt[issue_rd] != 0 raises a stall.
- stall output:
  - stall = issue_valid && !flush && (any RAW stall || WAW stall).
  - fwd_sel is don't-care while stall = 1; the bench checks it only when stall = 0.
- Per clock edge:
  - Shift: slot[k+1] <= slot[k], with rem decremented saturating at 0.
  - Slot 1 load: if issue_valid && !flush && !stall, slot1 <= {1, issue_we, issue_rd, lat-1}; otherwise slot1 <= bubble (valid = 0).
  - Exit from slot FWD_DEPTH: if valid && we && rd != 0 && rem > 1, then busy_cnt[rd] <= rem-1.
  - Every other nonzero busy_cnt decrements by 1.
  - The long-latency unit writes the register file on the edge where busy_cnt goes 1 -> 0; readers see the value from the register file the next cycle.
- Simultaneous events:
  - Exit load into a register's busy_cnt takes priority over that register's decrement.
  - flush with stall: flush wins, so stall = 0 and a bubble is inserted.
  - flush does not affect in-flight slots or busy counters.
- Latency: stall and fwd_sel are purely combinational from inputs and state. State updates take effect one cycle later.

Decomposition:
- Shared package fwd_pkg holds:
  - the slot entry struct {valid, we, rd, rem};
  - the constant SEL_RF = 0;
  - helper function lat_clamp.
- One sub-module, fwd_lookup: a per-operand youngest-match priority search returning {sel, raw_stall}. It is instantiated NUM_SRC times with a generate loop.
- Shift pipeline, busy table and stall OR-reduction stay in fwd_scoreboard.

Test Plan:
- Back-to-back ALU dependency: issue add r3 (lat 1); next cycle issue with src0 = r3 -> stall = 0, fwd_sel[0] = 1.
- Load-use: issue lw r5 (lat 2) at t; dependent on r5 at t+1 -> stall = 1 at t+1, then stall = 0 and fwd_sel = 2 at t+2.
- Long op beyond depth (FWD_DEPTH = 3):
  - Stimulus: issue mul r7 (lat 8) at t; reader of r7 held in ID from t+1.
  - Required: stall = 1 for exactly t+1..t+7; at t+8 stall = 0 and fwd_sel = 0.
  - Issuing another write to r7 at t+5 -> WAW stall = 1.
- Priority and r0:
  - Stimulus: writes to r4 in slot 2 (ready) and slot 1 (ready); a reader of r4 and r0.
  - Required: fwd_sel[0] = 1, fwd_sel[1] = 0, stall = 0; an r0 reader never stalls even after a write to r0 issues.
- Flush: a hazarding instruction with flush = 1 -> stall = 0; the next cycle slot1 is invalid, so a reader of its rd gets fwd_sel = 0.
- Reset mid-operation: assert rst_n = 0 while busy_cnt[r9] = 5 and slots are full -> all outputs 0 immediately; after release, a reader of r9 sees stall = 0 and fwd_sel = 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: shadow-slot entry, select encoding, latency clamp.
// Pure definitions; no timing and no flow control.
package fwd_pkg;

  localparam int FWD_REG_AW  = 5;
  localparam int FWD_MAX_LAT = 15;
  localparam int FWD_LAT_W   = $clog2(FWD_MAX_LAT + 1);
  localparam int SEL_RF      = 0;

  // rem counts cycles still needed before the result exists; 0 means forwardable now.
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [FWD_REG_AW-1:0] rd;
    logic [FWD_LAT_W-1:0]  rem;
  } slot_t;

  function automatic logic [FWD_LAT_W-1:0] lat_clamp(input logic [FWD_LAT_W-1:0] lat);
    if (lat == '0) return FWD_LAT_W'(1);
    if (int'(lat) > FWD_MAX_LAT) return FWD_LAT_W'(FWD_MAX_LAT);
    return lat;
  endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Per-operand youngest-match search over the shadow slots: forward select or RAW stall.
// Combinational, zero latency; raw_stall_o is the only backpressure it contributes.
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int REG_AW    = FWD_REG_AW,
  parameter int FWD_DEPTH = 3,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        src_valid_i,
  input  logic [REG_AW-1:0]           src_reg_i,
  input  logic                        busy_i,
  input  slot_t [FWD_DEPTH-1:0]       slots_i,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        raw_stall_o
);

  logic             hit;
  logic             hit_rdy;
  logic [SEL_W-1:0] hit_k;

  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_k   = '0;
    // Scan oldest to youngest so the youngest match overwrites any older one.
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (slots_i[k].valid && slots_i[k].we && slots_i[k].rd == src_reg_i) begin
        hit     = 1'b1;
        hit_rdy = (slots_i[k].rem == '0);
        hit_k   = SEL_W'(k + 1);
      end
    end

    sel_o       = SEL_W'(SEL_RF);
    raw_stall_o = 1'b0;
    if (src_valid_i && src_reg_i != '0) begin
      if (hit) begin
        if (hit_rdy) sel_o = hit_k;
        else         raw_stall_o = 1'b1;
      end else if (busy_i) begin
        raw_stall_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/interlock unit: shadow write pipeline, long-latency busy table, per-operand selects.
// stall/fwd_sel combinational from state; state updates next edge; stall holds ID and bubbles EX.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int REG_AW    = FWD_REG_AW,
  parameter  int NUM_SRC   = 2,
  parameter  int FWD_DEPTH = 3,
  parameter  int MAX_LAT   = FWD_MAX_LAT,
  localparam int LAT_W     = $clog2(MAX_LAT + 1),
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LAT_W-1:0]          issue_lat,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] src_reg,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
);

  localparam int NREG = 2 ** REG_AW;

  slot_t [FWD_DEPTH-1:0] slot_q, slot_d;
  logic [LAT_W-1:0]      busy_q [NREG];
  logic [LAT_W-1:0]      busy_d [NREG];
  logic [NUM_SRC-1:0]    raw_stall;
  logic                  waw_stall;
  logic                  load;
  slot_t                 exit_e;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_lookup #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
    ) u_lookup (
      .src_valid_i (src_valid[i]),
      .src_reg_i   (src_reg[i*REG_AW +: REG_AW]),
      .busy_i      (busy_q[src_reg[i*REG_AW +: REG_AW]] != '0),
      .slots_i     (slot_q),
      .sel_o       (fwd_sel[i*SEL_W +: SEL_W]),
      .raw_stall_o (raw_stall[i])
    );
  end

  assign waw_stall = issue_we && issue_rd != '0 && busy_q[issue_rd] != '0;
  assign stall     = issue_valid && !flush && (|raw_stall || waw_stall);
  assign load      = issue_valid && !flush && !stall;
  assign exit_e    = slot_q[FWD_DEPTH-1];

  always_comb begin
    slot_d = '0;
    if (load) begin
      slot_d[0].valid = 1'b1;
      slot_d[0].we    = issue_we;
      slot_d[0].rd    = issue_rd;
      slot_d[0].rem   = lat_clamp(issue_lat) - LAT_W'(1);
    end
    for (int k = 1; k < FWD_DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
      if (slot_q[k-1].rem != '0) slot_d[k].rem = slot_q[k-1].rem - LAT_W'(1);
    end

    for (int r = 0; r < NREG; r++) begin
      busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - LAT_W'(1) : '0;
    end
    // A result still pending when it leaves the forward window is tracked by its register.
    if (exit_e.valid && exit_e.we && exit_e.rd != '0 && exit_e.rem > LAT_W'(1)) begin
      busy_d[exit_e.rd] = exit_e.rem - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      for (int r = 0; r < NREG; r++) busy_q[r] <= '0;
    end else begin
      slot_q <= slot_d;
      for (int r = 0; r < NREG; r++) busy_q[r] <= busy_d[r];
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with hand-computed stall/select expectations.
module tb_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_we, flush;
  logic [4:0] issue_rd;
  logic [3:0] issue_lat;
  logic [1:0] src_valid;
  logic [9:0] src_reg;
  logic       stall;
  logic [3:0] fwd_sel;

  int n_cmp = 0;
  int n_bad = 0;

  fwd_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .issue_lat   (issue_lat),
    .flush       (flush),
    .src_valid   (src_valid),
    .src_reg     (src_reg),
    .stall       (stall),
    .fwd_sel     (fwd_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage request just after a rising edge, then settle.
  task automatic drv(input logic v, input logic we, input int rd, input int lat, input logic fl,
                     input logic s0v, input int s0, input logic s1v, input int s1);
    issue_valid = v;
    issue_we    = we;
    issue_rd    = 5'(rd);
    issue_lat   = 4'(lat);
    flush       = fl;
    src_valid   = {s1v, s0v};
    src_reg     = {5'(s1), 5'(s0)};
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  function automatic int sel0();
    return int'(fwd_sel[1:0]);
  endfunction

  function automatic int sel1();
    return int'(fwd_sel[3:2]);
  endfunction

  initial begin
    rst_n = 1'b0;
    drv(1, 1, 3, 1, 0, 1, 3, 1, 4);
    chk("reset_stall", int'(stall), 0);
    chk("reset_sel", int'(fwd_sel), 0);
    step();
    rst_n = 1'b1;
    step();

    // Back-to-back ALU dependency
    drv(1, 1, 3, 1, 0, 0, 0, 0, 0);
    chk("alu_issue_stall", int'(stall), 0);
    step();
    drv(1, 1, 10, 1, 0, 1, 3, 0, 0);
    chk("alu_dep_stall", int'(stall), 0);
    chk("alu_dep_sel0", sel0(), 1);
    step();
    idle(4);

    // Load-use
    drv(1, 1, 5, 2, 0, 0, 0, 0, 0);
    step();
    drv(1, 0, 0, 1, 0, 1, 5, 0, 0);
    chk("ld_use_t1_stall", int'(stall), 1);
    step();
    drv(1, 0, 0, 1, 0, 1, 5, 0, 0);
    chk("ld_use_t2_stall", int'(stall), 0);
    chk("ld_use_t2_sel0", sel0(), 2);
    step();
    idle(4);

    // Long op beyond the forward window; WAW probe at t+5
    drv(1, 1, 7, 8, 0, 0, 0, 0, 0);
    chk("mul_issue_stall", int'(stall), 0);
    step();
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) begin
        drv(1, 1, 7, 1, 0, 0, 0, 0, 0);
        chk("mul_waw_t5", int'(stall), 1);
      end else begin
        drv(1, 0, 0, 1, 0, 1, 7, 0, 0);
        chk($sformatf("mul_rd_t%0d", c), int'(stall), (c <= 7) ? 1 : 0);
      end
      if (c == 8) chk("mul_t8_sel0", sel0(), 0);
      step();
    end
    idle(4);

    // Priority: two ready copies of r4, plus r0 reader and r0 writer
    drv(1, 1, 4, 1, 0, 0, 0, 0, 0);
    step();
    drv(1, 1, 4, 1, 0, 0, 0, 0, 0);
    chk("r4_rewrite_stall", int'(stall), 0);
    step();
    drv(1, 1, 0, 8, 0, 1, 4, 1, 0);
    chk("prio_stall", int'(stall), 0);
    chk("prio_sel0", sel0(), 1);
    chk("prio_sel1_r0", sel1(), 0);
    step();
    for (int c = 0; c < 4; c++) begin
      drv(1, 0, 0, 1, 0, 1, 0, 1, 0);
      chk($sformatf("r0_stall_%0d", c), int'(stall), 0);
      chk($sformatf("r0_sel_%0d", c), int'(fwd_sel), 0);
      step();
    end
    idle(4);

    // Youngest not ready hides an older ready copy
    drv(1, 1, 11, 1, 0, 0, 0, 0, 0);
    step();
    drv(1, 1, 11, 3, 0, 0, 0, 0, 0);
    step();
    drv(1, 0, 0, 1, 0, 0, 0, 1, 11);
    chk("young_notrdy_stall", int'(stall), 1);
    step();
    idle(4);

    // issue_lat = 0 behaves as single-cycle
    drv(1, 1, 6, 0, 0, 0, 0, 0, 0);
    step();
    drv(1, 0, 0, 1, 0, 1, 6, 0, 0);
    chk("lat0_stall", int'(stall), 0);
    chk("lat0_sel0", sel0(), 1);
    step();
    idle(4);

    // Flush beats a RAW hazard and leaves a bubble
    drv(1, 1, 12, 2, 0, 0, 0, 0, 0);
    step();
    drv(1, 1, 13, 1, 1, 1, 12, 0, 0);
    chk("flush_stall", int'(stall), 0);
    step();
    drv(1, 0, 0, 1, 0, 1, 13, 1, 12);
    chk("post_flush_stall", int'(stall), 0);
    chk("post_flush_sel0", sel0(), 0);
    chk("post_flush_sel1", sel1(), 2);
    step();
    idle(4);

    // Reset mid-operation: busy[r9] = 5 and slots full
    drv(1, 1, 9, 9, 0, 0, 0, 0, 0);
    step();
    drv(1, 1, 14, 1, 0, 0, 0, 0, 0);
    step();
    drv(1, 1, 15, 1, 0, 0, 0, 0, 0);
    step();
    drv(1, 1, 16, 1, 0, 0, 0, 0, 0);
    step();
    drv(1, 0, 0, 1, 0, 1, 9, 1, 16);
    chk("pre_rst_stall", int'(stall), 1);
    chk("pre_rst_sel1", sel1(), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", int'(stall), 0);
    chk("mid_rst_sel", int'(fwd_sel), 0);
    step();
    rst_n = 1'b1;
    step();
    drv(1, 0, 0, 1, 0, 1, 9, 1, 16);
    chk("post_rst_stall", int'(stall), 0);
    chk("post_rst_sel", int'(fwd_sel), 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
